// File: rtl/m92_pkg.sv
// Shared types and helpers for the M92 palette mixer: palette geometry,
// the palette entry layout and the 5-bit to 8-bit channel expansion.
package m92_pkg;

  localparam int PAL_ENTRIES  = 2048;
  localparam int PAL_AW       = 11;
  localparam int OBJ_BANK_BIT = 10;

  // Palette word layout, MSB first: unused bit, blue, green, red.
  typedef struct packed {
    logic       x;
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } pal_entry_t;

  // Replicate the top bits into the low end so 5'h1F maps to 8'hFF.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

endpackage

// File: rtl/m92_palette_ram.sv
// 2048x16 true dual-port palette RAM in the dpramv_16 style.
// Port A: CPU side, byte-lane writes and a registered read that a same-cycle
// write suppresses. Port B: pixel side, read-first, advances only when en_b.
module m92_palette_ram
  import m92_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PAL_AW-1:0] addr_a,
  input  logic [15:0]       din_a,
  input  logic [1:0]        be_a,
  input  logic              we_a,
  input  logic              re_a,
  output logic [15:0]       q_a,
  input  logic              en_b,
  input  logic [PAL_AW-1:0] addr_b,
  output logic [15:0]       q_b
);

  logic [15:0] mem_r [0:PAL_ENTRIES-1];

  // CPU byte-lane writes; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (we_a) begin
      if (be_a[0]) begin
        mem_r[addr_a][7:0] <= din_a[7:0];
      end
      if (be_a[1]) begin
        mem_r[addr_a][15:8] <= din_a[15:8];
      end
    end
  end

  // CPU read data register; holds its value until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_a <= 16'h0000;
    end else if (re_a) begin
      q_a <= mem_r[addr_a];
    end
  end

  // Pixel-side read register; the old word is seen when the CPU writes the same entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_b <= 16'h0000;
    end else if (en_b) begin
      q_b <= mem_r[addr_b];
    end
  end

endmodule

// File: rtl/m92_palette_mixer.sv
// M92 pixel output stage: background/sprite priority select, palette lookup
// and RGB expansion, with blanking delayed to stay aligned with the colour.
// Stages (each on CE_PIX): select index -> palette read -> colour register.
module m92_palette_mixer
  import m92_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic        CLK_32M,
  input  logic        RESET_N,
  input  logic        CE_PIX,
  input  logic [10:0] bg_color,
  input  logic        bg_prio,
  input  logic [10:0] obj_color,
  input  logic        obj_prio,
  input  logic        HBL,
  input  logic        VBL,
  input  logic [10:0] A,
  input  logic [15:0] DIN,
  input  logic [1:0]  BYTE_SEL,
  input  logic        MRD,
  input  logic        MWR,
  input  logic        palette_memrq,
  output logic [15:0] DOUT,
  input  logic        en_palette,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        HBL_OUT,
  output logic        VBL_OUT
);

  logic                  bg_opaque_s;
  logic                  obj_opaque_s;
  logic [10:0]           sel_idx_s;
  logic [10:0]           sel_idx_r;
  logic [7:0]            grey_r;
  logic [PIPE_DEPTH-1:0] hbl_sr_r;
  logic [PIPE_DEPTH-1:0] vbl_sr_r;
  logic                  blank_s;
  logic                  cpu_we_s;
  logic                  cpu_re_s;
  logic [15:0]           ram_q_s;
  pal_entry_t            entry_s;
  logic [7:0]            r_nxt_s;
  logic [7:0]            g_nxt_s;
  logic [7:0]            b_nxt_s;
  logic                  unused_s;

  assign bg_opaque_s  = (bg_color[3:0] != 4'h0);
  assign obj_opaque_s = (obj_color[3:0] != 4'h0);

  // Priority select: an opaque sprite wins unless an opaque background has P1L set.
  always_comb begin
    sel_idx_s = {1'b0, bg_color[9:0]};
    if (obj_opaque_s && !(bg_prio && bg_opaque_s) &&
        !(!obj_prio && bg_opaque_s && bg_prio)) begin
      sel_idx_s               = {1'b0, obj_color[9:0]};
      sel_idx_s[OBJ_BANK_BIT] = 1'b1;
    end else begin
      sel_idx_s = {1'b0, bg_color[9:0]};
    end
  end

  // Stage 0: latch the winning palette index.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      sel_idx_r <= 11'h000;
    end else if (CE_PIX) begin
      sel_idx_r <= sel_idx_s;
    end
  end

  // Stage 1: carry the low index byte beside the RAM read for the debug grey path.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      grey_r <= 8'h00;
    end else if (CE_PIX) begin
      grey_r <= sel_idx_r[7:0];
    end
  end

  // Blanking delay line; resets to "blanked" so the flushed pipe shows nothing.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      hbl_sr_r <= {PIPE_DEPTH{1'b1}};
      vbl_sr_r <= {PIPE_DEPTH{1'b1}};
    end else if (CE_PIX) begin
      hbl_sr_r <= {hbl_sr_r[PIPE_DEPTH-2:0], HBL};
      vbl_sr_r <= {vbl_sr_r[PIPE_DEPTH-2:0], VBL};
    end
  end

  assign HBL_OUT = hbl_sr_r[PIPE_DEPTH-1];
  assign VBL_OUT = vbl_sr_r[PIPE_DEPTH-1];
  assign blank_s = hbl_sr_r[PIPE_DEPTH-2] | vbl_sr_r[PIPE_DEPTH-2];

  // CPU strobes: a write in the same cycle as a read takes precedence.
  assign cpu_we_s = palette_memrq & MWR;
  assign cpu_re_s = palette_memrq & MRD & ~MWR;

  m92_palette_ram u_ram (
    .clk    (CLK_32M),
    .rst_n  (RESET_N),
    .addr_a (A),
    .din_a  (DIN),
    .be_a   (BYTE_SEL),
    .we_a   (cpu_we_s),
    .re_a   (cpu_re_s),
    .q_a    (DOUT),
    .en_b   (CE_PIX),
    .addr_b (sel_idx_r),
    .q_b    (ram_q_s)
  );

  // Stage 2 colour: blanking forces black, debug mode shows the index as grey.
  always_comb begin
    entry_s = pal_entry_t'(ram_q_s);
    r_nxt_s = 8'h00;
    g_nxt_s = 8'h00;
    b_nxt_s = 8'h00;
    if (blank_s) begin
      r_nxt_s = 8'h00;
      g_nxt_s = 8'h00;
      b_nxt_s = 8'h00;
    end else if (!en_palette) begin
      r_nxt_s = grey_r;
      g_nxt_s = grey_r;
      b_nxt_s = grey_r;
    end else begin
      r_nxt_s = expand5(entry_s.r);
      g_nxt_s = expand5(entry_s.g);
      b_nxt_s = expand5(entry_s.b);
    end
  end

  // Stage 2: registered pixel colour outputs.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      R <= 8'h00;
      G <= 8'h00;
      B <= 8'h00;
    end else if (CE_PIX) begin
      R <= r_nxt_s;
      G <= g_nxt_s;
      B <= b_nxt_s;
    end
  end

  // Bits with no function here: the index zero-extension bit, sprite palette
  // bit 6 (outside the 1024-entry sprite bank) and the spare palette bit.
  assign unused_s = ^{bg_color[10], obj_color[10], entry_s.x};

endmodule

// File: tb/tb_m92_palette_mixer.sv
// Self-checking bench for m92_palette_mixer. Pixel expectations are pushed
// to a scoreboard queue with the CE_PIX tick at which they become visible
// and popped/compared when that tick has elapsed.
module tb_m92_palette_mixer;

  logic        CLK_32M = 1'b0;
  logic        RESET_N;
  logic        CE_PIX;
  logic [10:0] bg_color;
  logic        bg_prio;
  logic [10:0] obj_color;
  logic        obj_prio;
  logic        HBL;
  logic        VBL;
  logic [10:0] A;
  logic [15:0] DIN;
  logic [1:0]  BYTE_SEL;
  logic        MRD;
  logic        MWR;
  logic        palette_memrq;
  logic [15:0] DOUT;
  logic        en_palette;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        HBL_OUT;
  logic        VBL_OUT;

  m92_palette_mixer #(.PIPE_DEPTH(3)) dut (
    .CLK_32M       (CLK_32M),
    .RESET_N       (RESET_N),
    .CE_PIX        (CE_PIX),
    .bg_color      (bg_color),
    .bg_prio       (bg_prio),
    .obj_color     (obj_color),
    .obj_prio      (obj_prio),
    .HBL           (HBL),
    .VBL           (VBL),
    .A             (A),
    .DIN           (DIN),
    .BYTE_SEL      (BYTE_SEL),
    .MRD           (MRD),
    .MWR           (MWR),
    .palette_memrq (palette_memrq),
    .DOUT          (DOUT),
    .en_palette    (en_palette),
    .R             (R),
    .G             (G),
    .B             (B),
    .HBL_OUT       (HBL_OUT),
    .VBL_OUT       (VBL_OUT)
  );

  always #5 CLK_32M = ~CLK_32M;

  typedef struct {
    logic [25:0] px;   // {R, G, B, HBL_OUT, VBL_OUT}
    int          due;  // tick count at which the pixel is visible
  } sb_t;

  typedef struct packed {
    logic [10:0] bg;
    logic        bgp;
    logic [10:0] obj;
    logic        objp;
    logic        hbl;
    logic        vbl;
    logic [23:0] rgb;
  } prow_t;

  sb_t         sb_q[$];
  int          n_cmp    = 0;
  int          n_err    = 0;
  int          tick_cnt = 0;
  logic [15:0] model_mem [0:2047];

  localparam logic [25:0] FLUSHED = {24'h000000, 1'b1, 1'b1};

  task automatic clk1();
    @(posedge CLK_32M);
    @(negedge CLK_32M);
  endtask

  // One pixel period: CE_PIX high for one clock, optionally with a CPU write in that clock.
  task automatic pix_tick(input logic wr, input logic [10:0] wa, input logic [15:0] wd,
                          input logic [1:0] be);
    CE_PIX        = 1'b1;
    palette_memrq = wr;
    MWR           = wr;
    A             = wa;
    DIN           = wd;
    BYTE_SEL      = be;
    if (wr) begin
      if (be[0]) model_mem[wa][7:0]  = wd[7:0];
      if (be[1]) model_mem[wa][15:8] = wd[15:8];
    end
    clk1();
    CE_PIX        = 1'b0;
    palette_memrq = 1'b0;
    MWR           = 1'b0;
    tick_cnt++;
    clk1();
    clk1();
    clk1();
  endtask

  task automatic cpu_write(input logic [10:0] addr, input logic [15:0] data, input logic [1:0] be);
    palette_memrq = 1'b1;
    MWR           = 1'b1;
    MRD           = 1'b0;
    A             = addr;
    DIN           = data;
    BYTE_SEL      = be;
    if (be[0]) model_mem[addr][7:0]  = data[7:0];
    if (be[1]) model_mem[addr][15:8] = data[15:8];
    clk1();
    palette_memrq = 1'b0;
    MWR           = 1'b0;
  endtask

  task automatic cpu_read(input logic [10:0] addr, output logic [15:0] data);
    palette_memrq = 1'b1;
    MRD           = 1'b1;
    A             = addr;
    clk1();
    data          = DOUT;
    palette_memrq = 1'b0;
    MRD           = 1'b0;
  endtask

  task automatic push_px(input logic [25:0] px);
    sb_t s;
    s.px  = px;
    s.due = tick_cnt + 3;
    sb_q.push_back(s);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
    pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
    n_cmp++;
    if ({R, G, B, HBL_OUT, VBL_OUT} !== FLUSHED) begin
      n_err++;
      $display("FAIL reset_pixel: got %h expected %h", {R, G, B, HBL_OUT, VBL_OUT}, FLUSHED);
    end
    n_cmp++;
    if (DOUT !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_dout: got %h expected 0000", DOUT);
    end
    RESET_N = 1'b1;
    clk1();
  endtask

  task automatic test_cpu_rw();
    logic [15:0] rd;
    cpu_write(11'h005, 16'h7FFF, 2'b11);
    cpu_write(11'h412, 16'h001F, 2'b11);
    cpu_write(11'h023, 16'h03E0, 2'b11);
    cpu_write(11'h1F0, 16'h7C00, 2'b11);
    cpu_read(11'h005, rd);
    n_cmp++;
    if (rd !== 16'h7FFF) begin
      n_err++;
      $display("FAIL cpu_read_005: got %h expected 7fff", rd);
    end
    // Back-to-back reads on consecutive clocks.
    palette_memrq = 1'b1;
    MRD           = 1'b1;
    A             = 11'h412;
    clk1();
    n_cmp++;
    if (DOUT !== 16'h001F) begin
      n_err++;
      $display("FAIL b2b_read_412: got %h expected 001f", DOUT);
    end
    A = 11'h1F0;
    clk1();
    n_cmp++;
    if (DOUT !== 16'h7C00) begin
      n_err++;
      $display("FAIL b2b_read_1f0: got %h expected 7c00", DOUT);
    end
    // Read and write together: write lands, DOUT keeps the previous read.
    MWR      = 1'b1;
    A        = 11'h7FE;
    DIN      = 16'h0BAD;
    BYTE_SEL = 2'b11;
    model_mem[11'h7FE] = 16'h0BAD;
    clk1();
    n_cmp++;
    if (DOUT !== 16'h7C00) begin
      n_err++;
      $display("FAIL rd_wr_collision_dout: got %h expected 7c00", DOUT);
    end
    MWR = 1'b0;
    clk1();
    n_cmp++;
    if (DOUT !== 16'h0BAD) begin
      n_err++;
      $display("FAIL rd_after_collision: got %h expected 0bad", DOUT);
    end
    MRD           = 1'b0;
    palette_memrq = 1'b0;
  endtask

  task automatic test_pixel_paths();
    prow_t tbl [0:9];
    sb_t   e;
    int    k;
    k = 0;
    tbl[0] = {11'h005, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 24'hFFFFFF};
    tbl[1] = {11'h003, 1'b0, 11'h012, 1'b1, 1'b0, 1'b0, 24'hFF0000};
    tbl[2] = {11'h023, 1'b1, 11'h012, 1'b1, 1'b0, 1'b0, 24'h00FF00};
    tbl[3] = {11'h1F0, 1'b0, 11'h010, 1'b1, 1'b0, 1'b0, 24'h0000FF};
    tbl[4] = {11'h1F0, 1'b0, 11'h010, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[5] = {11'h005, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[6] = {11'h003, 1'b0, 11'h012, 1'b0, 1'b0, 1'b0, 24'hFF0000};
    tbl[7] = {11'h020, 1'b1, 11'h012, 1'b0, 1'b0, 1'b0, 24'hFF0000};
    tbl[8] = {11'h023, 1'b1, 11'h012, 1'b0, 1'b0, 1'b0, 24'h00FF00};
    tbl[9] = {11'h005, 1'b1, 11'h000, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
    en_palette = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        bg_color  = tbl[i].bg;
        bg_prio   = tbl[i].bgp;
        obj_color = tbl[i].obj;
        obj_prio  = tbl[i].objp;
        HBL       = tbl[i].hbl;
        VBL       = tbl[i].vbl;
        push_px({tbl[i].rgb, tbl[i].hbl, tbl[i].vbl});
      end else begin
        HBL = 1'b0;
        VBL = 1'b0;
      end
      pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
      if (sb_q.size() != 0 && sb_q[0].due == tick_cnt) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({R, G, B, HBL_OUT, VBL_OUT} !== e.px) begin
          n_err++;
          $display("FAIL pixel_path[%0d]: got %h expected %h", k, {R, G, B, HBL_OUT, VBL_OUT}, e.px);
        end
        k++;
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL pixel_path_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_byte_lane();
    logic [15:0] rd;
    sb_t         e;
    cpu_write(11'h0C7, 16'h1234, 2'b11);
    bg_color  = 11'h0C7;
    bg_prio   = 1'b0;
    obj_color = 11'h000;
    obj_prio  = 1'b0;
    HBL       = 1'b0;
    VBL       = 1'b0;
    push_px({24'hA58C21, 1'b0, 1'b0});            // old word 0x1234
    pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
    push_px({24'h6BB521, 1'b0, 1'b0});            // merged word 0x12CD
    pix_tick(1'b1, 11'h0C7, 16'hABCD, 2'b01);     // write collides with the pixel read
    for (int i = 0; i < 2; i++) begin
      pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
      if (sb_q.size() != 0 && sb_q[0].due == tick_cnt) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({R, G, B, HBL_OUT, VBL_OUT} !== e.px) begin
          n_err++;
          $display("FAIL byte_lane_pixel[%0d]: got %h expected %h", i, {R, G, B, HBL_OUT, VBL_OUT}, e.px);
        end
      end
    end
    cpu_read(11'h0C7, rd);
    n_cmp++;
    if (rd !== 16'h12CD) begin
      n_err++;
      $display("FAIL byte_lane_readback: got %h expected 12cd", rd);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL byte_lane_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_midline();
    logic [15:0] rd;
    sb_t         e;
    en_palette = 1'b1;
    bg_color   = 11'h005;
    obj_color  = 11'h000;
    bg_prio    = 1'b0;
    HBL        = 1'b0;
    VBL        = 1'b0;
    push_px({24'hFFFFFF, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
    end
    e = sb_q.pop_front();
    n_cmp++;
    if ({R, G, B, HBL_OUT, VBL_OUT} !== e.px) begin
      n_err++;
      $display("FAIL pre_reset_pixel: got %h expected %h", {R, G, B, HBL_OUT, VBL_OUT}, e.px);
    end
    // Put a pixel in flight, then pull reset for two clocks.
    bg_color = 11'h1F0;
    pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
    RESET_N = 1'b0;
    clk1();
    clk1();
    n_cmp++;
    if ({R, G, B, HBL_OUT, VBL_OUT} !== FLUSHED) begin
      n_err++;
      $display("FAIL midline_reset_pixel: got %h expected %h", {R, G, B, HBL_OUT, VBL_OUT}, FLUSHED);
    end
    n_cmp++;
    if (DOUT !== 16'h0000) begin
      n_err++;
      $display("FAIL midline_reset_dout: got %h expected 0000", DOUT);
    end
    RESET_N = 1'b1;
    sb_q.delete();
    // Grey debug path; nothing valid until the third tick after release.
    en_palette = 1'b0;
    bg_color   = 11'h0A5;
    push_px({24'hA5A5A5, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
      if (sb_q.size() != 0 && sb_q[0].due == tick_cnt) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({R, G, B, HBL_OUT, VBL_OUT} !== e.px) begin
          n_err++;
          $display("FAIL grey_pixel: got %h expected %h", {R, G, B, HBL_OUT, VBL_OUT}, e.px);
        end
      end else begin
        n_cmp++;
        if ({R, G, B, HBL_OUT, VBL_OUT} !== FLUSHED) begin
          n_err++;
          $display("FAIL post_reset_tick%0d: got %h expected %h", i + 1, {R, G, B, HBL_OUT, VBL_OUT}, FLUSHED);
        end
      end
    end
    en_palette = 1'b1;
    cpu_read(11'h005, rd);
    n_cmp++;
    if (rd !== 16'h7FFF) begin
      n_err++;
      $display("FAIL ram_kept_005: got %h expected 7fff", rd);
    end
    cpu_read(11'h412, rd);
    n_cmp++;
    if (rd !== 16'h001F) begin
      n_err++;
      $display("FAIL ram_kept_412: got %h expected 001f", rd);
    end
  endtask

  task automatic test_back_to_back();
    sb_t         e;
    logic [10:0] idx;
    logic [15:0] w;
    logic [25:0] px;
    int          k;
    k = 0;
    for (int j = 0; j < 64; j++) begin
      cpu_write(11'(j), 16'($urandom), 2'b11);
      cpu_write(11'(j + 1024), 16'($urandom), 2'b11);
    end
    en_palette = 1'b1;
    for (int i = 0; i < 42; i++) begin
      if (i < 40) begin
        bg_color  = {5'b00000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        obj_color = {1'($urandom_range(0, 1)), 4'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        bg_prio   = 1'($urandom_range(0, 1));
        obj_prio  = 1'($urandom_range(0, 1));
        HBL       = ($urandom_range(0, 7) == 0);
        VBL       = ($urandom_range(0, 9) == 0);
        if (bg_prio && bg_color[3:0] != 4'h0) idx = {1'b0, bg_color[9:0]};
        else if (obj_color[3:0] != 4'h0)      idx = {1'b1, obj_color[9:0]};
        else                                  idx = {1'b0, bg_color[9:0]};
        w = model_mem[idx];
        if (HBL || VBL) px = {24'h000000, HBL, VBL};
        else px = {w[4:0], w[4:2], w[9:5], w[9:7], w[14:10], w[14:12], 1'b0, 1'b0};
        push_px(px);
      end
      pix_tick(1'b0, 11'h000, 16'h0000, 2'b00);
      if (sb_q.size() != 0 && sb_q[0].due == tick_cnt) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({R, G, B, HBL_OUT, VBL_OUT} !== e.px) begin
          n_err++;
          $display("FAIL stream[%0d]: got %h expected %h", k, {R, G, B, HBL_OUT, VBL_OUT}, e.px);
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 40) begin
      n_err++;
      $display("FAIL stream_count: got %0d expected 40", k);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1);
  end

  initial begin
    RESET_N       = 1'b0;
    CE_PIX        = 1'b0;
    bg_color      = 11'h000;
    bg_prio       = 1'b0;
    obj_color     = 11'h000;
    obj_prio      = 1'b0;
    HBL           = 1'b0;
    VBL           = 1'b0;
    A             = 11'h000;
    DIN           = 16'h0000;
    BYTE_SEL      = 2'b00;
    MRD           = 1'b0;
    MWR           = 1'b0;
    palette_memrq = 1'b0;
    en_palette    = 1'b1;
    repeat (2) @(negedge CLK_32M);
    test_reset();
    test_cpu_rw();
    test_pixel_paths();
    test_byte_lane();
    test_reset_midline();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
